// File: rtl/half_narrow_unit.sv
// Narrows 32-bit words to 16-bit halfword beats: a word that survives sign/zero
// truncation leaves as one beat, any other word leaves as low half then high half.
module half_narrow_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      data_i,
  input  logic             signed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      data_o,
  output logic             last_o,
  output logic             split_o,
  output logic [CNT_W-1:0] split_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    ONE,
    LO,
    HI
  } state_t;

  state_t      state;
  logic [15:0] hi_q;
  logic        handshake;
  logic        accept;
  logic        fits;

  // A new word may enter on the same edge the final beat of the previous one leaves.
  assign handshake  = out_valid_o & out_ready_i;
  assign in_ready_o = !rst_i & ((state == IDLE) | (last_o & handshake));
  assign accept     = in_valid_i & in_ready_o;

  assign fits = signed_i ? ((&data_i[31:15]) | ~(|data_i[31:15]))
                         : ~(|data_i[31:16]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      hi_q        <= '0;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      last_o      <= 1'b0;
      split_o     <= 1'b0;
      split_cnt_o <= '0;
    end else if (accept) begin
      hi_q        <= data_i[31:16];
      out_valid_o <= 1'b1;
      data_o      <= data_i[15:0];
      if (fits) begin
        state   <= ONE;
        last_o  <= 1'b1;
        split_o <= 1'b0;
      end else begin
        state   <= LO;
        last_o  <= 1'b0;
        split_o <= 1'b1;
        if (split_cnt_o != {CNT_W{1'b1}})
          split_cnt_o <= split_cnt_o + CNT_W'(1);
      end
    end else if (handshake) begin
      case (state)
        LO: begin
          state  <= HI;
          data_o <= hi_q;
          last_o <= 1'b1;
        end
        ONE, HI: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
          last_o      <= 1'b0;
          split_o     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
